regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order writeback stage and the multi-cycle RV32M mul/div unit, whose results complete out of order.
- Buffers mul/div results and keeps a pending-destination scoreboard.
- Generates the decode-stage stall for RAW/WAW hazards on pending registers.
- Sits beside decode; drives the register file wr_en/wr_addr/wr_data inputs.

---
 rtl/regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the in-order writeback
// stage and an out-of-order completing mul/div unit. Mul/div results are
// queued in a small FIFO; a pending-destination scoreboard tracks issued
// mul/div ops whose results have not yet been written, and decode is stalled
// on RAW/WAW hazards against those registers, when the outstanding-op limit
// is reached, or when a buffered result has lost arbitration for too long.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   wb_valid/wb_rd/wb_data  writeback-stage register write request
//   dec_rs1/dec_rs2/dec_rd/dec_we  decode-stage operand/destination info
//   md_req / md_issue     mul/div request from decode / accepted this cycle
//   md_done/md_rd/md_data/md_ready  mul/div result handshake
//   rf_wr_en/rf_wr_addr/rf_wr_data  register file write port
//   stall                 hold fetch/decode and insert a bubble
//   pending_cnt           issued mul/div ops not yet written back
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wb_valid,
    input  logic [4:0]                     wb_rd,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic [4:0]                     dec_rs1,
    input  logic [4:0]                     dec_rs2,
    input  logic [4:0]                     dec_rd,
    input  logic                           dec_we,
    input  logic                           md_req,
    output logic                           md_issue,
    input  logic                           md_done,
    input  logic [4:0]                     md_rd,
    input  logic [DATA_W-1:0]              md_data,
    output logic                           md_ready,
    output logic                           rf_wr_en,
    output logic [4:0]                     rf_wr_addr,
    output logic [DATA_W-1:0]              rf_wr_data,
    output logic                           stall,
    output logic [$clog2(BUF_DEPTH):0]     pending_cnt
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

    // Wrap a FIFO pointer at the last buffer entry
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic [4:0]        buf_rd_r   [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_r [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       pending_r;
    logic [CNT_W-1:0]  pend_cnt_r;
    logic [STV_W-1:0]  starve_r;

    logic              buf_empty_s;
    logic              wb_win_s;
    logic              pop_s;
    logic              push_s;
    logic [4:0]        head_rd_s;
    logic [DATA_W-1:0] head_data_s;
    logic              stall_s;
    logic [31:0]       pending_nxt_s;

    assign buf_empty_s = (count_r == {CNT_W{1'b0}});
    assign wb_win_s    = wb_valid & (wb_rd != 5'd0);
    assign head_rd_s   = buf_rd_r[rd_ptr_r];
    assign head_data_s = buf_data_r[rd_ptr_r];

    // md_ready depends only on registered occupancy, never on md_done
    assign md_ready    = rst & (count_r < DEPTH_C);
    assign push_s      = md_done & md_ready;
    assign stall       = stall_s;
    assign md_issue    = rst & md_req & ~stall_s;
    assign pending_cnt = pend_cnt_r;

    // Write-port arbitration: WB first, then the buffer head; x0 never written
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = 5'd0;
        rf_wr_data = {DATA_W{1'b0}};
        pop_s      = 1'b0;
        if (!rst) begin
            pop_s = 1'b0;
        end else if (wb_win_s) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = wb_rd;
            rf_wr_data = wb_data;
        end else if (!buf_empty_s) begin
            // A buffered x0 result still pops so pending_cnt drains
            pop_s      = 1'b1;
            rf_wr_en   = (head_rd_s != 5'd0);
            rf_wr_addr = head_rd_s;
            rf_wr_data = head_data_s;
        end else begin
            rf_wr_en = 1'b0;
        end
    end

    // Decode hazard detection: RAW, WAW, outstanding-op limit, starvation
    always_comb begin
        stall_s = 1'b0;
        if (!rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((dec_rs1 != 5'd0) & pending_r[dec_rs1])
                    | ((dec_rs2 != 5'd0) & pending_r[dec_rs2])
                    | (dec_we & (dec_rd != 5'd0) & pending_r[dec_rd])
                    | (md_req & (pend_cnt_r == DEPTH_C))
                    | (starve_r == STARVE_C);
        end
    end

    // Next scoreboard value: clear the popped destination, then set the
    // issued one so a same-index set overrides the clear
    always_comb begin
        pending_nxt_s = pending_r;
        if (pop_s) begin
            pending_nxt_s[head_rd_s] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (md_issue && (dec_rd != 5'd0)) begin
            pending_nxt_s[dec_rd] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Result FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_rd_r[i]   <= 5'd0;
                buf_data_r[i] <= {DATA_W{1'b0}};
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                buf_rd_r[wr_ptr_r]   <= md_rd;
                buf_data_r[wr_ptr_r] <= md_data;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Pending scoreboard and outstanding-op counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r  <= 32'd0;
            pend_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            case ({md_issue, pop_s})
                2'b10:   pend_cnt_r <= pend_cnt_r + CNT_W'(1);
                2'b01:   pend_cnt_r <= pend_cnt_r - CNT_W'(1);
                default: pend_cnt_r <= pend_cnt_r;
            endcase
        end
    end

    // Starvation counter: cycles a waiting buffered result has lost to WB
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_r <= {STV_W{1'b0}};
        end else if (pop_s || buf_empty_s) begin
            starve_r <= {STV_W{1'b0}};
        end else if (wb_win_s && (starve_r != STARVE_C)) begin
            starve_r <= starve_r + STV_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Expected register-file writes are
// queued when the stimulus that causes them is driven and popped whenever the
// DUT asserts rf_wr_en; control outputs are compared against hand-derived
// values at each step.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_we, md_req, md_issue, md_done, md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        stall;
    logic [1:0]  pending_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    regfile_wb_arbiter #(.DATA_W(32), .BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
        .md_req(md_req), .md_issue(md_issue),
        .md_done(md_done), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .stall(stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // End of a cycle: score any register write, then advance past the edge
    task automatic cyc();
        logic [36:0] e;
        #2;
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 64'(rf_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_port", 64'({rf_wr_addr, rf_wr_data}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        md_req = 1'b1; dec_rd = rd; dec_we = 1'b1;
        #2;
        chk("md_issue", 64'(md_issue), 64'd1);
        cyc();
        md_req = 1'b0; dec_rd = 5'd0; dec_we = 1'b0;
    endtask

    initial begin
        // Reset held two edges with live inputs
        rst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd5; dec_we = 1'b1;
        md_req = 1'b1; md_done = 1'b1; md_rd = 5'd5; md_data = 32'h1;
        cyc(); cyc();
        #2;
        chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rst_md_ready", 64'(md_ready), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_md_issue", 64'(md_issue), 64'd0);
        chk("rst_pending_cnt", 64'(pending_cnt), 64'd0);
        rst = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; md_req = 1'b0; md_done = 1'b0;
        dec_rd = 5'd0; dec_we = 1'b0;
        #1;
        chk("post_rst_md_ready", 64'(md_ready), 64'd1);
        cyc();

        // Free port: issue, complete, written one cycle later
        issue(5'd5);
        md_done = 1'b1; md_rd = 5'd5; md_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        #2;
        chk("free_pending_cnt1", 64'(pending_cnt), 64'd1);
        chk("free_no_bypass", 64'(rf_wr_en), 64'd0);
        cyc();
        md_done = 1'b0;
        #2;
        chk("free_wr_en", 64'(rf_wr_en), 64'd1);
        cyc();

        // RAW on x7 via rs2
        #2;
        chk("free_pending_cnt0", 64'(pending_cnt), 64'd0);
        issue(5'd7);
        dec_rs2 = 5'd7;
        #2;
        chk("raw_stall_a", 64'(stall), 64'd1);
        cyc();
        md_done = 1'b1; md_rd = 5'd7; md_data = 32'h00007777;
        expect_wr(5'd7, 32'h00007777);
        #2;
        chk("raw_stall_b", 64'(stall), 64'd1);
        cyc();
        md_done = 1'b0;
        #2;
        chk("raw_stall_on_write", 64'(stall), 64'd1);
        chk("raw_wr_en", 64'(rf_wr_en), 64'd1);
        cyc();
        #2;
        chk("raw_stall_clear", 64'(stall), 64'd0);
        dec_rs2 = 5'd0;

        // x0 destination: no pending bit, pops without a write
        issue(5'd0);
        md_done = 1'b1; md_rd = 5'd0; md_data = 32'h12345678;
        #2;
        chk("x0_no_stall", 64'(stall), 64'd0);
        chk("x0_pending_cnt1", 64'(pending_cnt), 64'd1);
        cyc();
        md_done = 1'b0;
        #2;
        chk("x0_no_wr", 64'(rf_wr_en), 64'd0);
        cyc();
        #2;
        chk("x0_pending_cnt0", 64'(pending_cnt), 64'd0);

        // Contention: x3 buffered while WB writes x9 every cycle
        issue(5'd3);
        md_done = 1'b1; md_rd = 5'd3; md_data = 32'h00003333;
        cyc();
        md_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9000 + 32'(k);
            expect_wr(5'd9, 32'h9000 + 32'(k));
            #2;
            chk("starve_stall", 64'(stall), (k >= 4) ? 64'd1 : 64'd0);
            cyc();
        end
        wb_valid = 1'b0; wb_rd = 5'd0;
        expect_wr(5'd3, 32'h00003333);
        #2;
        chk("starve_pop_wr_en", 64'(rf_wr_en), 64'd1);
        cyc();
        #2;
        chk("starve_stall_clear", 64'(stall), 64'd0);
        chk("starve_pending_cnt0", 64'(pending_cnt), 64'd0);

        // Full: two outstanding ops block a third, full buffer ignores md_done
        issue(5'd1);
        issue(5'd2);
        md_req = 1'b1; dec_rd = 5'd6; dec_we = 1'b1;
        #2;
        chk("full_stall", 64'(stall), 64'd1);
        chk("full_no_issue", 64'(md_issue), 64'd0);
        chk("full_pending_cnt2", 64'(pending_cnt), 64'd2);
        cyc();
        md_req = 1'b0; dec_rd = 5'd0; dec_we = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
        expect_wr(5'd10, 32'hA0);
        md_done = 1'b1; md_rd = 5'd1; md_data = 32'h1111;
        cyc();
        wb_data = 32'hA1; expect_wr(5'd10, 32'hA1);
        md_rd = 5'd2; md_data = 32'h2222;
        #2;
        chk("full_ready_one", 64'(md_ready), 64'd1);
        cyc();
        wb_data = 32'hA2; expect_wr(5'd10, 32'hA2);
        md_rd = 5'd12; md_data = 32'hCCCC;
        #2;
        chk("full_not_ready_a", 64'(md_ready), 64'd0);
        cyc();
        wb_data = 32'hA3; expect_wr(5'd10, 32'hA3);
        #2;
        chk("full_not_ready_b", 64'(md_ready), 64'd0);
        cyc();
        wb_valid = 1'b0; wb_rd = 5'd0;
        expect_wr(5'd1, 32'h1111);
        #2;
        chk("full_not_ready_pop", 64'(md_ready), 64'd0);
        cyc();
        md_done = 1'b0;
        expect_wr(5'd2, 32'h2222);
        #2;
        chk("full_ready_again", 64'(md_ready), 64'd1);
        cyc();
        #2;
        chk("full_pending_cnt0", 64'(pending_cnt), 64'd0);
        chk("full_nothing_captured", 64'(rf_wr_en), 64'd0);

        // WAW on x4
        issue(5'd4);
        dec_we = 1'b1; dec_rd = 5'd4;
        #2;
        chk("waw_stall", 64'(stall), 64'd1);
        cyc();
        dec_we = 1'b0;
        md_done = 1'b1; md_rd = 5'd4; md_data = 32'h4444;
        expect_wr(5'd4, 32'h4444);
        #2;
        chk("waw_no_we_no_stall", 64'(stall), 64'd0);
        cyc();
        md_done = 1'b0; dec_rd = 5'd0;
        cyc();
        #2;
        chk("waw_pending_cnt0", 64'(pending_cnt), 64'd0);

        // Reset mid-operation discards buffered result and pending bit
        issue(5'd8);
        md_done = 1'b1; md_rd = 5'd8; md_data = 32'h8888;
        cyc();
        rst = 1'b0; md_done = 1'b0;
        cyc();
        rst = 1'b1; dec_rs1 = 5'd8;
        #2;
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_pending_cnt", 64'(pending_cnt), 64'd0);
        chk("midrst_no_wr", 64'(rf_wr_en), 64'd0);
        cyc();
        dec_rs1 = 5'd0;

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
